// File: rtl/wb_local_memory_bridge_pkg.sv
// Shared definitions for the Wishbone-to-local-memory bridge.
// Holds the controller state encoding, the read fill value that
// unselected byte lanes return, and the request sanity helper.
package wb_local_memory_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } bridge_state_e;

  // Value seen on unselected read lanes of the local memory.
  localparam logic [31:0] LOCAL_READ_FILL = 32'hFFFF_FFFF;

  // A request is rejected up front when it is not word aligned or
  // selects no byte lane at all; such requests never reach memory.
  function automatic logic bad_request(input logic [1:0] adr_lo,
                                       input logic [3:0] sel);
    return (adr_lo != 2'b00) || (sel == 4'b0000);
  endfunction

endpackage

// File: rtl/wb_local_memory_bridge.sv
// Wishbone classic slave issuing one held-enable local memory request per
// transfer; ack on completion, err on misalignment/empty select/timeout.
// Ports: clk, rst (sync, active-high); wb_* slave side; local* requester
// side (address/sel/enable/we/wdata out, rdata/busy in).
// Latency: strobe sample -> ack is 2 cycles plus one per busy cycle.
// Backpressure: localBusy stretches ACCESS up to TIMEOUT_CYCLES edges.
module wb_local_memory_bridge
  import wb_local_memory_bridge_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [ADDRESS_SIZE-1:0] wb_adr_i,
  input  logic [31:0]             wb_data_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [31:0]             wb_data_o,
  output logic [ADDRESS_SIZE-1:0] localAddress,
  output logic [3:0]              localByteSelect,
  output logic                    localEnable,
  output logic                    localWriteEnable,
  output logic [31:0]             localDataWrite,
  input  logic [31:0]             localDataRead,
  input  logic                    localBusy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    en_q, en_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [ADDRESS_SIZE-1:0] adr_q, adr_d;
  logic [31:0]             wdat_q, wdat_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    en_d    = en_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d  = wb_adr_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          wdat_d = wb_data_i;
          if (bad_request(wb_adr_i[1:0], wb_sel_i)) begin
            state_d = ST_RESPOND;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            en_d    = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        // Priority: master abort, then completion, then timeout.
        if (!wb_cyc_i) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (!localBusy) begin
          if (!we_q) begin
            rdata_d = localDataRead;
          end
          en_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The response pulse is the registered ack/err; any strobe seen
      // here belongs to the finished transfer and is ignored.
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign wb_ack_o         = ack_q;
  assign wb_err_o         = err_q;
  assign wb_data_o        = rdata_q;
  assign localAddress     = adr_q;
  assign localByteSelect  = sel_q;
  assign localEnable      = en_q;
  assign localWriteEnable = we_q;
  assign localDataWrite   = wdat_q;

endmodule
